// File: rtl/tdm_mux.sv
// -----------------------------------------------------------------------------
// tdm_mux
//
// Registered N-channel multiplexer with valid/ready on every input and on the
// output. Channel selection is either fixed (by sel) or round-robin across the
// channels that currently offer data. A single output register gives one cycle
// of latency and one word per cycle throughput.
//
// Configuration macro:
//   TDM_MUX_RR_EN  defined   -> round-robin logic and rr_ptr are built and
//                               mode selects fixed (0) / round-robin (1).
//                  undefined -> mode is ignored, block is always fixed-select,
//                               no rr_ptr register; port list is unchanged.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. in_ready is at most one-hot, is never high for a
// channel whose in_valid is low, and does not depend on the data itself.
//
// Ports:
//   clk        in   sole clock, all state on rising edge
//   reset      in   synchronous active-high reset
//   in         in   CHANNELS*WIDTH flattened inputs, channel c at [c*WIDTH +: WIDTH]
//   in_valid   in   per-channel data valid
//   in_ready   out  per-channel accept (at most one bit high)
//   sel        in   channel index used in fixed mode
//   mode       in   0 = fixed select, 1 = round-robin
//   out        out  registered data
//   out_valid  out  out holds an untaken word
//   out_chan   out  source channel of out
//   out_ready  in   downstream accept
// -----------------------------------------------------------------------------
module tdm_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
);

  logic             load;
  logic             fix_vld;
  logic             grant_vld;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new word when it is empty or when its
  // current word leaves on this same edge (consume-and-refill).
  assign load = !out_valid || out_ready;

  // Fixed mode: compare sel against every real channel, so an out-of-range
  // sel (non-power-of-2 CHANNELS) simply matches nothing and never grants.
  always_comb begin
    fix_vld = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((sel == SELW'(c)) && in_valid[c]) begin
        fix_vld = 1'b1;
      end
    end
  end

`ifdef TDM_MUX_RR_EN
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_grant;
  logic            rr_vld;
  logic [SELW-1:0] rr_next;
  int              best_dist;
  int              dist;

  // Round-robin: among valid channels pick the one with the smallest forward
  // distance from rr_ptr (wrapping at CHANNELS). Distance-based so that
  // non-power-of-2 channel counts wrap correctly.
  always_comb begin
    rr_vld    = 1'b0;
    rr_grant  = '0;
    best_dist = CHANNELS;
    dist      = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (c >= int'(rr_ptr)) begin
        dist = c - int'(rr_ptr);
      end else begin
        dist = c + CHANNELS - int'(rr_ptr);
      end
      if (in_valid[c] && (dist < best_dist)) begin
        best_dist = dist;
        rr_grant  = SELW'(c);
        rr_vld    = 1'b1;
      end
    end
  end

  always_comb begin
    if (grant == SELW'(CHANNELS - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant + SELW'(1);
    end
  end

  // Pointer moves only on a round-robin transfer; fixed transfers and
  // stalls leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (load && grant_vld && mode) begin
      rr_ptr <= rr_next;
    end
  end

  always_comb begin
    grant_vld = fix_vld;
    grant     = sel;
    if (mode) begin
      grant_vld = rr_vld;
      grant     = rr_grant;
    end
  end
`else
  // Without round-robin support mode has no effect.
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    grant_vld = fix_vld;
    grant     = sel;
  end
`endif

  // Data of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant == SELW'(c)) begin
        grant_data = in[c*WIDTH +: WIDTH];
      end
    end
  end

  // Accept is forced low while reset is asserted so no word is taken and lost.
  always_comb begin
    in_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c] = !reset && load && grant_vld && (grant == SELW'(c));
    end
  end

  // Output register. With load and no grant only out_valid drops; out and
  // out_chan keep the last word for visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
    end else if (load) begin
      if (grant_vld) begin
        out       <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
